ttc_decoder: RTL and testbench

Receive-side decoder for the 2-bit-per-clk_40 legacy TTC stream produced by the on-board TTC generator. Frames are three 2-bit symbols. The block recovers frames, emits single-cycle trigger, BCR, ECR and master-reset pulses, and maintains the local bunch-crossing and event counters. It sits in the TDC-side logic, directly behind the TTC input pins.

---
 rtl/ttc_pkg.sv | 24 ++
 rtl/ttc_frame_rx.sv | 98 +++++++++
 rtl/ttc_decoder.sv | 82 ++++++++
 tb/tb_ttc_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ttc_pkg.sv
// Shared constants, state encoding and helpers for the legacy TTC receive decoder.
package ttc_pkg;

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_ONE  = 2'b11;

  localparam logic [3:0] PL_BCR  = 4'b1100;
  localparam logic [3:0] PL_TRIG = 4'b0000;
  localparam logic [3:0] PL_ECR  = 4'b1111;
  localparam logic [3:0] PL_MRST = 4'b0011;

  localparam int BC_MAX_DEF = 3563;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAY1 = 2'd1,
    ST_PAY2 = 2'd2
  } rx_state_e;

  function automatic logic sym_legal(input logic [1:0] sym);
    return (sym == SYM_IDLE) || (sym == SYM_ONE);
  endfunction

endpackage

// File: rtl/ttc_frame_rx.sv
// Frame recovery FSM: turns the 2-bit symbol stream into registered command and error pulses.
//   state   | meaning
//   ST_IDLE | hunting for start symbol 11
//   ST_PAY1 | start seen, next symbol is P1
//   ST_PAY2 | P1 captured, next symbol is P2 (decode)
module ttc_frame_rx
  import ttc_pkg::*;
(
  input  logic       clk_40,
  input  logic       rst_40,
  input  logic [1:0] ttc_in,
  input  logic       decode_en,
  output logic       trigger,
  output logic       bcr,
  output logic       ecr,
  output logic       master_reset,
  output logic       frame_error,
  // next-cycle strobes so the counters can load on the same edge that registers the pulse
  output logic       bcr_nxt,
  output logic       ecr_nxt,
  output logic       mrst_nxt,
  output logic       err_nxt
);

  rx_state_e  state_q, state_d;
  logic [1:0] p1_q, p1_d;
  logic       trig_q, trig_d;
  logic       bcr_q, bcr_d;
  logic       ecr_q, ecr_d;
  logic       mrst_q, mrst_d;
  logic       err_q, err_d;

  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      state_q <= ST_IDLE;
      p1_q    <= SYM_IDLE;
      trig_q  <= 1'b0;
      bcr_q   <= 1'b0;
      ecr_q   <= 1'b0;
      mrst_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      trig_q  <= trig_d;
      bcr_q   <= bcr_d;
      ecr_q   <= ecr_d;
      mrst_q  <= mrst_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    trig_d  = 1'b0;
    bcr_d   = 1'b0;
    ecr_d   = 1'b0;
    mrst_d  = 1'b0;
    err_d   = 1'b0;
    if (!decode_en) begin
      state_d = ST_IDLE;
    end else if (!sym_legal(ttc_in)) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (ttc_in == SYM_ONE) state_d = ST_PAY1;
        ST_PAY1: begin
          p1_d    = ttc_in;
          state_d = ST_PAY2;
        end
        ST_PAY2: begin
          state_d = ST_IDLE;
          case ({p1_q, ttc_in})
            PL_BCR:  bcr_d  = 1'b1;
            PL_TRIG: trig_d = 1'b1;
            PL_ECR:  ecr_d  = 1'b1;
            PL_MRST: mrst_d = 1'b1;
            default: ;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign trigger      = trig_q;
  assign bcr          = bcr_q;
  assign ecr          = ecr_q;
  assign master_reset = mrst_q;
  assign frame_error  = err_q;
  assign bcr_nxt      = bcr_d;
  assign ecr_nxt      = ecr_d;
  assign mrst_nxt     = mrst_d;
  assign err_nxt      = err_d;

endmodule

// File: rtl/ttc_decoder.sv
// TTC receive decoder top: frame recovery plus bunch-crossing, event and error counters.
module ttc_decoder
  import ttc_pkg::*;
#(
  parameter int BC_MAX     = BC_MAX_DEF,
  parameter int BCR_OFFSET = 0,
  parameter int EVID_W     = 24
) (
  input  logic              clk_40,
  input  logic              rst_40,
  input  logic [1:0]        ttc_in,
  input  logic              decode_en,
  output logic              trigger,
  output logic              bcr,
  output logic              ecr,
  output logic              master_reset,
  output logic              frame_error,
  output logic [11:0]       bcid,
  output logic [EVID_W-1:0] event_id,
  output logic [7:0]        error_count
);

  localparam logic [11:0]       BC_LAST = 12'(BC_MAX);
  localparam logic [11:0]       BC_LOAD = 12'(BCR_OFFSET);
  localparam logic [EVID_W-1:0] EVID_ONE = {{(EVID_W-1){1'b0}}, 1'b1};

  logic bcr_nxt, ecr_nxt, mrst_nxt, err_nxt;

  logic [11:0]       bcid_q, bcid_d;
  logic [EVID_W-1:0] event_id_q, event_id_d;
  logic [7:0]        error_count_q, error_count_d;

  ttc_frame_rx u_frame_rx (
    .clk_40       (clk_40),
    .rst_40       (rst_40),
    .ttc_in       (ttc_in),
    .decode_en    (decode_en),
    .trigger      (trigger),
    .bcr          (bcr),
    .ecr          (ecr),
    .master_reset (master_reset),
    .frame_error  (frame_error),
    .bcr_nxt      (bcr_nxt),
    .ecr_nxt      (ecr_nxt),
    .mrst_nxt     (mrst_nxt),
    .err_nxt      (err_nxt)
  );

  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      bcid_q        <= '0;
      event_id_q    <= '0;
      error_count_q <= '0;
    end else begin
      bcid_q        <= bcid_d;
      event_id_q    <= event_id_d;
      error_count_q <= error_count_d;
    end
  end

  always_comb begin
    bcid_d        = bcid_q + 12'd1;
    event_id_d    = event_id_q;
    error_count_d = error_count_q;

    // a BCR landing on the wrap cycle must win over the wrap
    if (bcr_nxt || mrst_nxt)  bcid_d = BC_LOAD;
    else if (bcid_q == BC_LAST) bcid_d = '0;

    // the ID advances as the trigger pulse ends, so the pulse carries its own ID
    if (ecr_nxt || mrst_nxt) event_id_d = '0;
    else if (trigger)        event_id_d = event_id_q + EVID_ONE;

    if (mrst_nxt)                              error_count_d = '0;
    else if (err_nxt && error_count_q != 8'hFF) error_count_d = error_count_q + 8'd1;
  end

  assign bcid        = bcid_q;
  assign event_id    = event_id_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_ttc_decoder.sv
// Self-checking bench for ttc_decoder: directed scenarios plus random symbol streams vs. a frame-level model.
module tb_ttc_decoder;

  localparam int BC_MAX     = 3563;
  localparam int BCR_OFFSET = 0;
  localparam int EVID_W     = 24;

  logic              clk_40 = 1'b0;
  logic              rst_40 = 1'b1;
  logic [1:0]        ttc_in = 2'b00;
  logic              decode_en = 1'b1;
  logic              trigger, bcr, ecr, master_reset, frame_error;
  logic [11:0]       bcid;
  logic [EVID_W-1:0] event_id;
  logic [7:0]        error_count;

  ttc_decoder #(
    .BC_MAX     (BC_MAX),
    .BCR_OFFSET (BCR_OFFSET),
    .EVID_W     (EVID_W)
  ) dut (
    .clk_40       (clk_40),
    .rst_40       (rst_40),
    .ttc_in       (ttc_in),
    .decode_en    (decode_en),
    .trigger      (trigger),
    .bcr          (bcr),
    .ecr          (ecr),
    .master_reset (master_reset),
    .frame_error  (frame_error),
    .bcid         (bcid),
    .event_id     (event_id),
    .error_count  (error_count)
  );

  always #5 clk_40 = ~clk_40;

  int n_tests = 0;
  int n_fail  = 0;

  // frame-level reference: symbols of the frame in progress, plus expected outputs
  int q[$];
  int e_trig, e_bcr, e_ecr, e_mrst, e_err, e_bcid, e_evid, e_errc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    e_trig = 0; e_bcr = 0; e_ecr = 0; e_mrst = 0; e_err = 0;
    e_bcid = 0; e_evid = 0; e_errc = 0;
  endtask

  task automatic model_edge(input int sym, input bit en);
    int  code;
    bit  prev_trig;
    prev_trig = (e_trig != 0);
    e_trig = 0; e_bcr = 0; e_ecr = 0; e_mrst = 0; e_err = 0;
    if (!en) begin
      q.delete();
    end else if (sym == 1 || sym == 2) begin
      e_err = 1;
      q.delete();
    end else if (q.size() == 0) begin
      if (sym == 3) q.push_back(sym);
    end else begin
      q.push_back(sym);
      if (q.size() == 3) begin
        code = (q[1] == 3 ? 2 : 0) + (q[2] == 3 ? 1 : 0);
        case (code)
          2: e_bcr  = 1;
          0: e_trig = 1;
          3: e_ecr  = 1;
          default: e_mrst = 1;
        endcase
        q.delete();
      end
    end
    if (e_bcr != 0 || e_mrst != 0) e_bcid = BCR_OFFSET;
    else                           e_bcid = (e_bcid + 1) % (BC_MAX + 1);
    if (e_ecr != 0 || e_mrst != 0) e_evid = 0;
    else if (prev_trig)            e_evid = (e_evid + 1) % (1 << EVID_W);
    if (e_mrst != 0)                   e_errc = 0;
    else if (e_err != 0 && e_errc < 255) e_errc = e_errc + 1;
  endtask

  task automatic check_all();
    check_val("trigger",      32'(trigger),      32'(e_trig));
    check_val("bcr",          32'(bcr),          32'(e_bcr));
    check_val("ecr",          32'(ecr),          32'(e_ecr));
    check_val("master_reset", 32'(master_reset), 32'(e_mrst));
    check_val("frame_error",  32'(frame_error),  32'(e_err));
    check_val("bcid",         32'(bcid),         32'(e_bcid));
    check_val("event_id",     32'(event_id),     32'(e_evid));
    check_val("error_count",  32'(error_count),  32'(e_errc));
  endtask

  task automatic step(input int sym, input bit en = 1'b1);
    ttc_in    = sym[1:0];
    decode_en = en;
    @(posedge clk_40);
    #1;
    model_edge(sym, en);
    check_all();
  endtask

  task automatic send(input int a, input int b, input int c);
    step(a);
    step(b);
    step(c);
  endtask

  task automatic do_reset();
    rst_40    = 1'b1;
    ttc_in    = 2'b00;
    decode_en = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk_40);
    #1;
    check_all();
    #2;
    rst_40 = 1'b0;
  endtask

  initial begin
    int r;
    #2;
    do_reset();

    // BCR frame starting in cycle 10
    repeat (9) step(0);
    send(3, 3, 0);
    check_val("bcr_cyc13", 32'(bcr), 32'd1);
    check_val("bcid_cyc13", 32'(bcid), 32'(BCR_OFFSET));
    step(0);
    check_val("bcr_cyc14", 32'(bcr), 32'd0);
    check_val("bcid_cyc14", 32'(bcid), 32'(BCR_OFFSET + 1));

    // three back-to-back triggers
    for (int k = 0; k < 3; k++) begin
      step(3);
      check_val("trig_gap", 32'(trigger), 32'd0);
      step(0);
      step(0);
      check_val("trig_pulse", 32'(trigger), 32'd1);
      check_val("trig_evid", 32'(event_id), 32'(k));
    end
    step(0);
    check_val("evid_after3", 32'(event_id), 32'd3);

    // free-run wrap, then a BCR landing on the wrap cycle
    do_reset();
    for (int i = 0; i < 4000 && e_bcid != BC_MAX; i++) step(0);
    check_val("bcid_max", 32'(bcid), 32'(BC_MAX));
    step(0);
    check_val("bcid_wrap", 32'(bcid), 32'd0);
    for (int i = 0; i < 4000 && e_bcid != BC_MAX - 2; i++) step(0);
    send(3, 3, 0);
    check_val("bcr_on_wrap", 32'(bcr), 32'd1);
    check_val("bcid_on_wrap", 32'(bcid), 32'(BCR_OFFSET));
    step(0);
    check_val("bcid_after_wrap_bcr", 32'(bcid), 32'(BCR_OFFSET + 1));

    // illegal symbol mid-frame, then ECR
    do_reset();
    send(3, 0, 0);
    step(0);
    check_val("evid_pre_ecr", 32'(event_id), 32'd1);
    step(3);
    step(2);
    check_val("ferr_pulse", 32'(frame_error), 32'd1);
    step(0);
    check_val("ferr_clear", 32'(frame_error), 32'd0);
    check_val("no_cmd_after_err", 32'({trigger, bcr, ecr, master_reset}), 32'd0);
    check_val("errc_one", 32'(error_count), 32'd1);
    send(3, 3, 3);
    check_val("ecr_pulse", 32'(ecr), 32'd1);
    check_val("ecr_evid", 32'(event_id), 32'd0);

    // error saturation, then master reset
    do_reset();
    send(3, 0, 0);
    step(0);
    repeat (300) step(1);
    check_val("errc_sat", 32'(error_count), 32'd255);
    send(3, 0, 3);
    check_val("mrst_pulse", 32'(master_reset), 32'd1);
    check_val("mrst_errc", 32'(error_count), 32'd0);
    check_val("mrst_evid", 32'(event_id), 32'd0);
    check_val("mrst_bcid", 32'(bcid), 32'(BCR_OFFSET));

    // asynchronous reset between P1 and P2
    repeat (5) step(0);
    step(3);
    step(0);
    #3;
    rst_40 = 1'b1;
    ttc_in = 2'b00;
    #1;
    model_reset();
    check_val("async_rst_bcid", 32'(bcid), 32'd0);
    check_all();
    @(posedge clk_40);
    #2;
    rst_40 = 1'b0;
    repeat (3) step(0);
    send(3, 3, 0);
    check_val("post_rst_bcr", 32'(bcr), 32'd1);

    // decode_en low aborts a partial frame silently
    step(3);
    step(3, 1'b0);
    step(0);
    check_val("en_abort", 32'({trigger, bcr, ecr, master_reset, frame_error}), 32'd0);

    // randomized stream against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        send(3, ($urandom_range(0, 1) != 0) ? 3 : 0, ($urandom_range(0, 1) != 0) ? 3 : 0);
      end else if (r < 34) begin
        step($urandom_range(1, 2));
      end else if (r < 38) begin
        step(($urandom_range(0, 1) != 0) ? 3 : 0, 1'b0);
      end else begin
        step(($urandom_range(0, 2) == 0) ? 3 : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
